systolic_ctrl: RTL
==================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for the weight-stationary systolic array. Accepts one matmul command (active cols, input rows).
//  Runs the full sequence: column-enable config, weight-row load from the unified buffer, shadow->active switch,
//  input streaming, and output drain. Sits between the top-level instruction decoder and the systolic array.
// PARAMETERS
//  ARRAY_W        2   array width/height; weight rows loaded per command; width of accept_w/valid_in
//  ROWS_W         8   width of the input-row count
//  DRAIN_TIMEOUT  64  max DRAIN cycles without all outputs seen before forced abort
// PORTS
//  clk               in   1        clock, all state on posedge
//  rst               in   1        reset, asynchronous, active-low
//  cmd_valid         in   1        command present
//  cmd_ready         out  1        high only in IDLE
//  cmd_cols          in   16       active columns requested
//  cmd_rows          in   ROWS_W   input vectors to stream
//  w_req             out  1        weight-row read request to unified buffer
//  w_valid           in   1        weight row on array weight bus this cycle
//  accept_w          out  ARRAY_W  per-column accept_w to array
//  sys_switch        out  1        switch pulse to array top-left PE
//  sys_start         out  1        input-valid to array; also input-buffer read strobe
//  col_size          out  16       column-enable count to array
//  col_size_valid    out  1        col_size strobe
//  sys_valid_in      in   ARRAY_W  bottom-row valid_out from array
//  busy              out  1        state != IDLE
//  done              out  1        1-cycle completion pulse
//  err               out  1        1-cycle pulse with done on drain timeout
// BEHAVIOUR
//  Reset (rst=0, any time incl. mid-op): state=IDLE, all counters 0, every output 0 except cmd_ready=1.
//  Latched cols: cmd_cols==0 or >ARRAY_W -> ARRAY_W, else cmd_cols. Rows latched as-is.
//  FSM, transitions on posedge:
//   IDLE   : cmd_ready=1; cmd_valid&cmd_ready -> latch, go CFG. No other output active.
//   CFG    : 1 cycle; col_size_valid=1, col_size=cols (col_size holds value until next CFG); rows==0 -> DONE else LOAD_W.
//   LOAD_W : w_req=1; accept_w[i]=w_valid & (i<cols) (combinational); wcnt++ per w_valid cycle;
//            w_valid with wcnt==ARRAY_W-1 -> SWITCH. w_valid low stalls with no timeout.
//   SWITCH : 1 cycle; sys_switch=1 -> STREAM.
//   STREAM : sys_start=1 exactly rows consecutive cycles (rcnt 0..rows-1) -> DRAIN.
//   DRAIN  : ocnt++ on each cycle sys_valid_in[cols-1]=1, counted also during STREAM.
//            ocnt==rows -> DONE. DRAIN_TIMEOUT cycles in DRAIN without that -> DONE with err.
//   DONE   : 1 cycle; done=1 (err=1 if timeout) -> IDLE.
//  Outputs other than accept_w and cmd_ready are registered (glitch-free).
//  Latency: w_valid held high -> accept at edge 0, CFG cycle 0, LOAD_W 1..ARRAY_W, SWITCH ARRAY_W+1,
//   sys_start ARRAY_W+2 .. ARRAY_W+1+rows.
//  Counters: wcnt $clog2(ARRAY_W)+1 bits, rcnt/ocnt ROWS_W+1 bits, no wrap within a command.
//   Timeout counter $clog2(DRAIN_TIMEOUT)+1 bits. All counters clear on entry to CFG.
//  cmd_valid while busy: ignored, not queued; the command must be held until cmd_ready.
//  sys_valid_in bits >= cols ignored.
// TESTING
//  T1 ARRAY_W=2, cols=2, rows=3, w_valid always 1:
//     col_size_valid @c0 (col_size=2); accept_w=2'b11 @c1,c2; switch @c3; start @c4-c6;
//     valid[1] high 3 cycles -> done 1 pulse, err=0.
//  T2 cols=1, rows=2, w_valid low c1-c3 then high: w_req held, accept_w=2'b01 only when w_valid;
//     switch 1 cycle after 2nd accept.
//  T3 cmd_cols=0 and cmd_cols=5: col_size=2 both; cmd_rows=0: CFG then done next cycle,
//     no w_req, sys_switch or sys_start.
//  T4 rows=2, sys_valid_in tied 0: DRAIN lasts 64 cycles -> done=1, err=1 same cycle, then IDLE, cmd_ready=1.
//  T5 rst low mid-STREAM (after 1 of 4 starts): sys_start drops asynchronously, all outputs 0, cmd_ready=1;
//     a new command after release runs from CFG.
//  T6 cmd_valid pulsed during LOAD_W with different cols: ignored; latched cols unchanged.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Command, weight-load and array-control signals shared by the systolic
// sequencer (slave) and its driver: decoder, buffer and array (master).
interface systolic_ctrl_if #(
  parameter int ARRAY_W = 2,
  parameter int ROWS_W  = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [15:0]         cmd_cols;
  logic [ROWS_W-1:0]   cmd_rows;
  logic                w_req;
  logic                w_valid;
  logic [ARRAY_W-1:0]  accept_w;
  logic                sys_switch;
  logic                sys_start;
  logic [15:0]         col_size;
  logic                col_size_valid;
  logic [ARRAY_W-1:0]  sys_valid_in;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_cols, cmd_rows, w_valid, sys_valid_in,
    input  cmd_ready, w_req, accept_w, sys_switch, sys_start,
           col_size, col_size_valid, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_cols, cmd_rows, w_valid, sys_valid_in,
    output cmd_ready, w_req, accept_w, sys_switch, sys_start,
           col_size, col_size_valid, busy, done, err
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Matmul sequencer for the weight-stationary systolic array: column config,
// weight-row load, shadow/active switch, input streaming and output drain.
module systolic_ctrl #(
  parameter int ARRAY_W       = 2,
  parameter int ROWS_W        = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  systolic_ctrl_if.slave  bus
);

  localparam int WCW = $clog2(ARRAY_W) + 1;
  localparam int RCW = ROWS_W + 1;
  localparam int TCW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WC_ONE = 1;
  localparam logic [RCW-1:0] RC_ONE = 1;
  localparam logic [TCW-1:0] TC_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, CFG, LOAD_W, SWITCH, STREAM, DRAIN, DONE
  } state_t;

  state_t            state;
  logic [15:0]       cols_q;
  logic [ROWS_W-1:0] rows_q;
  logic [WCW-1:0]    wcnt;
  logic [RCW-1:0]    rcnt;
  logic [RCW-1:0]    ocnt;
  logic [TCW-1:0]    tcnt;

  logic [15:0]       cols_eff;
  logic [RCW-1:0]    rows_ext;
  logic              out_hit;
  logic [RCW-1:0]    ocnt_nxt;

  assign rows_ext      = {1'b0, rows_q};
  assign bus.cmd_ready = (state == IDLE);

  always_comb begin
    cols_eff = bus.cmd_cols;
    if (bus.cmd_cols == 16'd0 || bus.cmd_cols > 16'(ARRAY_W))
      cols_eff = 16'(ARRAY_W);
  end

  // Only the last active column's bottom-row valid marks a finished output row;
  // ocnt saturates at rows so stray extra valids cannot overshoot the target.
  always_comb begin
    out_hit = 1'b0;
    for (int i = 0; i < ARRAY_W; i++)
      if (cols_q == 16'(i + 1))
        out_hit = bus.sys_valid_in[i];
    ocnt_nxt = (out_hit && ocnt != rows_ext) ? ocnt + RC_ONE : ocnt;
  end

  always_comb begin
    bus.accept_w = '0;
    for (int i = 0; i < ARRAY_W; i++)
      bus.accept_w[i] = (state == LOAD_W) && bus.w_valid && (16'(i) < cols_q);
  end

  // Registered outputs are set on the transition into the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cols_q             <= '0;
      rows_q             <= '0;
      wcnt               <= '0;
      rcnt               <= '0;
      ocnt               <= '0;
      tcnt               <= '0;
      bus.w_req          <= 1'b0;
      bus.sys_switch     <= 1'b0;
      bus.sys_start      <= 1'b0;
      bus.col_size       <= '0;
      bus.col_size_valid <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.err            <= 1'b0;
    end else begin
      bus.col_size_valid <= 1'b0;
      bus.sys_switch     <= 1'b0;
      bus.done           <= 1'b0;
      bus.err            <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state              <= CFG;
            cols_q             <= cols_eff;
            rows_q             <= bus.cmd_rows;
            wcnt               <= '0;
            rcnt               <= '0;
            ocnt               <= '0;
            tcnt               <= '0;
            bus.col_size       <= cols_eff;
            bus.col_size_valid <= 1'b1;
            bus.busy           <= 1'b1;
          end
        end
        CFG: begin
          if (rows_q == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state     <= LOAD_W;
            bus.w_req <= 1'b1;
          end
        end
        LOAD_W: begin
          if (bus.w_valid) begin
            wcnt <= wcnt + WC_ONE;
            if (wcnt == WCW'(ARRAY_W - 1)) begin
              state          <= SWITCH;
              bus.w_req      <= 1'b0;
              bus.sys_switch <= 1'b1;
            end
          end
        end
        SWITCH: begin
          state         <= STREAM;
          bus.sys_start <= 1'b1;
        end
        STREAM: begin
          ocnt <= ocnt_nxt;
          rcnt <= rcnt + RC_ONE;
          if (rcnt == rows_ext - RC_ONE) begin
            state         <= DRAIN;
            bus.sys_start <= 1'b0;
          end
        end
        DRAIN: begin
          ocnt <= ocnt_nxt;
          if (ocnt_nxt == rows_ext) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (tcnt == TCW'(DRAIN_TIMEOUT - 1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
          end else begin
            tcnt <= tcnt + TC_ONE;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
